// File: rtl/jump_issue_sched_pkg.sv
// jump_issue_sched_pkg
//   Shared definitions for the jump/branch issue scheduler:
//   - scheduler state encoding (IDLE, ISSUE, WAIT, FLUSH)
//   - decoded-word geometry and the source-operand field positions
//     (rs1, rs2, rs1_re, rs2_re) used by decode and the execution units
//   - operand_free(): one source operand's contribution to the head ready rule
package jump_issue_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_e;

  localparam int ADDR_W = 32;
  localparam int INST_W = 72;

  // Decoded-word source-operand fields
  localparam int RS1_HI     = 49;
  localparam int RS1_LO     = 45;
  localparam int RS2_HI     = 44;
  localparam int RS2_LO     = 40;
  localparam int RS1_RE_BIT = 38;
  localparam int RS2_RE_BIT = 37;

  // An operand blocks issue only if it is actually read, is not x0,
  // and the scoreboard reports a pending write to it.
  function automatic logic operand_free(input logic        re,
                                        input logic [4:0]  rs,
                                        input logic [31:0] busy);
    return !re || (rs == 5'd0) || !busy[rs];
  endfunction

endpackage

// File: rtl/jump_sched_fifo.sv
// jump_sched_fifo
//   In-order storage for queued jump-class entries ({addr, inst}).
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     push, pop   write at tail / retire head (ignored when full / empty)
//     flush       drop all entries, keeping the read pointer (wr_ptr := rd_ptr)
//     clear       drop all entries and return both pointers to 0
//     wr_data     entry written on push
//     head_data   oldest entry (combinational, feeds the ready check)
//     full, empty occupancy flags
//     count       occupied entries
//   Priority: rst > clear > flush > push/pop.
module jump_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 104
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic push_ok;
  logic pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push_ok && !clear && !flush) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  assign head_data = mem[rd_ptr_reg];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= rd_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/jump_issue_sched.sv
// jump_issue_sched
//   In-order issue queue and scheduler for the single jump/branch unit
//   (port iq_jump_0). The oldest entry issues once its source operands are
//   free; the next issue waits until the current one resolves. A taken
//   resolution flushes all younger (wrong-path) entries.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     enq_valid_i/ready_o decode handshake; enq_addr_i (PC), enq_inst_i (decoded word)
//     reg_busy_i          scoreboard, bit n = xn has a pending write
//     iq_jump_0_en_o      one-cycle issue strobe; iq_jump_0_addr_o/inst_o issued entry
//     jump_flag_i         jump unit redirect-taken, sampled in the last WAIT cycle
//     flush_i             external pipeline flush
//     busy_o              queue non-empty or scheduler not IDLE
//     count_o             occupied entries
//   Optional build macro JUMP_SCHED_STATS_EN adds stat_issued_o, stat_taken_o,
//   stat_stall_o (32-bit wrapping event counters).
module jump_issue_sched
  import jump_issue_sched_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int RESOLVE_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid_i,
  output logic                    enq_ready_o,
  input  logic [31:0]             enq_addr_i,
  input  logic [71:0]             enq_inst_i,
  input  logic [31:0]             reg_busy_i,
  output logic                    iq_jump_0_en_o,
  output logic [31:0]             iq_jump_0_addr_o,
  output logic [71:0]             iq_jump_0_inst_o,
  input  logic                    jump_flag_i,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  count_o
`ifdef JUMP_SCHED_STATS_EN
  ,
  output logic [31:0]             stat_issued_o,
  output logic [31:0]             stat_taken_o,
  output logic [31:0]             stat_stall_o
`endif
);

  localparam int ENTRY_W = ADDR_W + INST_W;
  localparam int WAIT_W  = $clog2(RESOLVE_LAT + 1);

  sched_state_e state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;

  logic               en_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [INST_W-1:0]  inst_reg;

  logic [ENTRY_W-1:0] head_data;
  logic [ADDR_W-1:0]  head_addr;
  logic [INST_W-1:0]  head_inst;
  logic               head_ready;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               last_wait;

  assign head_addr = head_data[ENTRY_W-1:INST_W];
  assign head_inst = head_data[INST_W-1:0];

  assign head_ready =
      operand_free(head_inst[RS1_RE_BIT], head_inst[RS1_HI:RS1_LO], reg_busy_i) &&
      operand_free(head_inst[RS2_RE_BIT], head_inst[RS2_HI:RS2_LO], reg_busy_i);

  // rst term forces ready low during the reset cycle itself.
  assign enq_ready_o = !rst && !fifo_full && (state_reg != ST_FLUSH);
  // A push coinciding with flush_i is dropped (the FIFO clear also overrides it).
  assign push        = enq_valid_i && enq_ready_o && !flush_i;
  assign pop         = (state_reg == ST_ISSUE);
  assign last_wait   = (state_reg == ST_WAIT) && (wait_cnt_reg == WAIT_W'(RESOLVE_LAT));

  jump_sched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (state_reg == ST_FLUSH),
    .clear     (flush_i),
    .wr_data   ({enq_addr_i, enq_inst_i}),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_o)
  );

  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (!fifo_empty && head_ready) state_next = ST_ISSUE;
        ST_ISSUE: state_next = ST_WAIT;
        ST_WAIT:  if (last_wait) state_next = jump_flag_i ? ST_FLUSH : ST_IDLE;
        ST_FLUSH: state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Issue outputs are loaded on the transition into ISSUE, so en is high
  // exactly while the state register holds ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      en_reg       <= 1'b0;
      addr_reg     <= '0;
      inst_reg     <= '0;
    end else begin
      state_reg <= state_next;
      en_reg    <= (state_next == ST_ISSUE);
      if (state_next == ST_ISSUE) begin
        addr_reg <= head_addr;
        inst_reg <= head_inst;
      end
      // Counter reads 1 in the first WAIT cycle and RESOLVE_LAT in the last.
      if (state_next == ST_WAIT) begin
        wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + WAIT_W'(1) : WAIT_W'(1);
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  assign iq_jump_0_en_o   = en_reg;
  assign iq_jump_0_addr_o = addr_reg;
  assign iq_jump_0_inst_o = inst_reg;
  assign busy_o           = !fifo_empty || (state_reg != ST_IDLE);

`ifdef JUMP_SCHED_STATS_EN
  logic [31:0] stat_issued_reg;
  logic [31:0] stat_taken_reg;
  logic [31:0] stat_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_reg <= '0;
      stat_taken_reg  <= '0;
      stat_stall_reg  <= '0;
    end else begin
      if (state_reg == ST_ISSUE) stat_issued_reg <= stat_issued_reg + 32'd1;
      // Only a resolution that actually enters FLUSH counts as taken.
      if (last_wait && jump_flag_i && !flush_i) stat_taken_reg <= stat_taken_reg + 32'd1;
      if ((state_reg == ST_IDLE) && !fifo_empty && !head_ready)
        stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_issued_o = stat_issued_reg;
  assign stat_taken_o  = stat_taken_reg;
  assign stat_stall_o  = stat_stall_reg;
`endif

endmodule

// File: tb/tb_jump_issue_sched.sv
module tb_jump_issue_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid_i = 1'b0;
  logic        enq_ready_o;
  logic [31:0] enq_addr_i = '0;
  logic [71:0] enq_inst_i = '0;
  logic [31:0] reg_busy_i = '0;
  logic        iq_jump_0_en_o;
  logic [31:0] iq_jump_0_addr_o;
  logic [71:0] iq_jump_0_inst_o;
  logic        jump_flag_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic [2:0]  count_o;
`ifdef JUMP_SCHED_STATS_EN
  logic [31:0] stat_issued_o, stat_taken_o, stat_stall_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  jump_issue_sched #(.DEPTH(4), .RESOLVE_LAT(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .enq_valid_i      (enq_valid_i),
    .enq_ready_o      (enq_ready_o),
    .enq_addr_i       (enq_addr_i),
    .enq_inst_i       (enq_inst_i),
    .reg_busy_i       (reg_busy_i),
    .iq_jump_0_en_o   (iq_jump_0_en_o),
    .iq_jump_0_addr_o (iq_jump_0_addr_o),
    .iq_jump_0_inst_o (iq_jump_0_inst_o),
    .jump_flag_i      (jump_flag_i),
    .flush_i          (flush_i),
    .busy_o           (busy_o),
    .count_o          (count_o)
`ifdef JUMP_SCHED_STATS_EN
    ,
    .stat_issued_o    (stat_issued_o),
    .stat_taken_o     (stat_taken_o),
    .stat_stall_o     (stat_stall_o)
`endif
  );

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [71:0] inst;
    logic        flag;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic [71:0] exp_inst;
    logic [2:0]  exp_cnt;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[10];
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk_inst(input logic [6:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic re1,
                                          input logic re2, input logic [31:0] imm);
    logic [71:0] w;
    w = '0;
    w[71:65] = op;
    w[49:45] = rs1;
    w[44:40] = rs2;
    w[38]    = re1;
    w[37]    = re2;
    w[34:3]  = imm;
    return w;
  endfunction

  function automatic vec_t mkv(input logic v, input logic [31:0] a, input logic [71:0] inst,
                               input logic flag, input logic en, input logic [31:0] ea,
                               input logic [71:0] ei, input logic [2:0] cnt, input logic bsy);
    vec_t r;
    r.v = v; r.a = a; r.inst = inst; r.flag = flag;
    r.exp_en = en; r.exp_addr = ea; r.exp_inst = ei; r.exp_cnt = cnt; r.exp_busy = bsy;
    return r;
  endfunction

  // Waits (bounded) for an issue strobe and checks the issued PC.
  task automatic wait_en(input logic [31:0] exp_a, input string nm);
    int n = 0;
    while (iq_jump_0_en_o !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk($sformatf("%s en", nm), iq_jump_0_en_o, 1'b1);
    chk($sformatf("%s addr", nm), iq_jump_0_addr_o, exp_a);
  endtask

  logic [71:0] beq_i, jal_i, jalr_i, blk_i;

  initial begin
    beq_i  = mk_inst(7'h63, 5'd5, 5'd6, 1'b1, 1'b1, 32'h0000_0040);
    jal_i  = mk_inst(7'h6F, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0000_0800);
    jalr_i = mk_inst(7'h67, 5'd3, 5'd9, 1'b1, 1'b0, 32'h0000_0010);
    blk_i  = mk_inst(7'h63, 5'd7, 5'd0, 1'b1, 1'b1, 32'h0000_0020);

    // Case 2 table: inputs applied in cycle i, expectations observed at start of cycle i.
    // Flag is raised in the first WAIT cycle (row 3) and must be ignored.
    tbl[0] = mkv(1, 32'h100, beq_i, 0, 0, 32'h0,   72'h0, 3'd0, 0);
    tbl[1] = mkv(1, 32'h104, jal_i, 0, 0, 32'h0,   72'h0, 3'd1, 1);
    tbl[2] = mkv(0, 32'h0,   72'h0, 0, 1, 32'h100, beq_i, 3'd2, 1);
    tbl[3] = mkv(0, 32'h0,   72'h0, 1, 0, 32'h0,   72'h0, 3'd1, 1);
    tbl[4] = mkv(0, 32'h0,   72'h0, 0, 0, 32'h0,   72'h0, 3'd1, 1);
    tbl[5] = mkv(0, 32'h0,   72'h0, 0, 0, 32'h0,   72'h0, 3'd1, 1);
    tbl[6] = mkv(0, 32'h0,   72'h0, 0, 1, 32'h104, jal_i, 3'd1, 1);
    tbl[7] = mkv(0, 32'h0,   72'h0, 0, 0, 32'h0,   72'h0, 3'd0, 1);
    tbl[8] = mkv(0, 32'h0,   72'h0, 0, 0, 32'h0,   72'h0, 3'd0, 1);
    tbl[9] = mkv(0, 32'h0,   72'h0, 0, 0, 32'h0,   72'h0, 3'd0, 0);

    // ---- Case 1: reset with enq_valid held high
    rst = 1'b1; enq_valid_i = 1'b1; enq_addr_i = 32'hDEAD; enq_inst_i = jal_i;
    tick();
    chk("rst ready", enq_ready_o, 1'b0);
    chk("rst en", iq_jump_0_en_o, 1'b0);
    chk("rst count", count_o, 3'd0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst addr", iq_jump_0_addr_o, 32'h0);
    chk("rst inst", iq_jump_0_inst_o, 72'h0);
    tick();
    chk("rst2 ready", enq_ready_o, 1'b0);
    chk("rst2 count", count_o, 3'd0);
    rst = 1'b0; enq_valid_i = 1'b0;
    tick();
    chk("post-rst ready", enq_ready_o, 1'b1);
    chk("post-rst count", count_o, 3'd0);
    $display("case1 reset done");

    // ---- Case 2: not-taken branch, table driven
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("c2[%0d] en", i), iq_jump_0_en_o, tbl[i].exp_en);
      if (tbl[i].exp_en) begin
        chk($sformatf("c2[%0d] addr", i), iq_jump_0_addr_o, tbl[i].exp_addr);
        chk($sformatf("c2[%0d] inst", i), iq_jump_0_inst_o, tbl[i].exp_inst);
      end
      chk($sformatf("c2[%0d] count", i), count_o, tbl[i].exp_cnt);
      chk($sformatf("c2[%0d] busy", i), busy_o, tbl[i].exp_busy);
      enq_valid_i = tbl[i].v; enq_addr_i = tbl[i].a; enq_inst_i = tbl[i].inst;
      jump_flag_i = tbl[i].flag;
      tick();
      $display("c2 cycle %0d en=%0d addr=%0h count=%0d", i, iq_jump_0_en_o, iq_jump_0_addr_o, count_o);
    end
    enq_valid_i = 1'b0; jump_flag_i = 1'b0;

    // ---- Case 3: busy rs1 stalls for 5 cycles; unread rs2 busy is ignored
    reg_busy_i = 32'h0000_0208;
    enq_valid_i = 1'b1; enq_addr_i = 32'h200; enq_inst_i = jalr_i;
    tick();
    enq_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("c3 stall%0d en", k), iq_jump_0_en_o, 1'b0);
      tick();
    end
    reg_busy_i = 32'h0000_0200;
    chk("c3 release en", iq_jump_0_en_o, 1'b0);
    tick();
    chk("c3 issue en", iq_jump_0_en_o, 1'b1);
    chk("c3 issue addr", iq_jump_0_addr_o, 32'h200);
    tick();
    chk("c3 wait1 en", iq_jump_0_en_o, 1'b0);
    tick();
    tick();
    chk("c3 idle busy", busy_o, 1'b0);
    reg_busy_i = '0;
    $display("case3 busy operand done");

    // ---- Case 4: taken jump with 3 younger entries
    reg_busy_i = 32'h0000_0080;
    for (int k = 0; k < 4; k++) begin
      enq_valid_i = 1'b1; enq_addr_i = 32'h300 + 32'(4 * k);
      enq_inst_i = (k == 0) ? blk_i : jal_i;
      tick();
    end
    enq_valid_i = 1'b0;
    chk("c4 full ready", enq_ready_o, 1'b0);
    chk("c4 full count", count_o, 3'd4);
    reg_busy_i = '0;
    enq_valid_i = 1'b1; enq_addr_i = 32'h310; enq_inst_i = jal_i;   // dropped: full
    tick();
    chk("c4 issue en", iq_jump_0_en_o, 1'b1);
    chk("c4 issue addr", iq_jump_0_addr_o, 32'h300);
    chk("c4 issue count", count_o, 3'd4);
    enq_valid_i = 1'b0;
    tick();
    chk("c4 wait1 count", count_o, 3'd3);
    tick();
    jump_flag_i = 1'b1;
    tick();
    jump_flag_i = 1'b0;
    chk("c4 flush ready", enq_ready_o, 1'b0);
    chk("c4 flush en", iq_jump_0_en_o, 1'b0);
    enq_valid_i = 1'b1; enq_addr_i = 32'h314;                      // dropped: FLUSH
    tick();
    enq_valid_i = 1'b0;
    chk("c4 after count", count_o, 3'd0);
    chk("c4 after ready", enq_ready_o, 1'b1);
    chk("c4 after busy", busy_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("c4 quiet%0d en", k), iq_jump_0_en_o, 1'b0);
      tick();
    end
    $display("case4 taken flush done");

    // ---- Case 5: full, then issue/resolve/push x10 across pointer wrap
    reg_busy_i = 32'h0000_0080;
    for (int k = 0; k < 4; k++) begin
      enq_valid_i = 1'b1; enq_addr_i = 32'h400 + 32'(4 * k);
      enq_inst_i = (k == 0) ? blk_i : jal_i;
      exp_q.push_back(enq_addr_i);
      tick();
    end
    enq_valid_i = 1'b0;
    chk("c5 full ready", enq_ready_o, 1'b0);
    chk("c5 full count", count_o, 3'd4);
    reg_busy_i = '0;
    for (int it = 0; it < 10; it++) begin
      wait_en(exp_q.pop_front(), $sformatf("c5 it%0d", it));
      tick();
      chk($sformatf("c5 it%0d en pulse", it), iq_jump_0_en_o, 1'b0);
      chk($sformatf("c5 it%0d ready", it), enq_ready_o, 1'b1);
      enq_valid_i = 1'b1; enq_addr_i = 32'h500 + 32'(4 * it); enq_inst_i = jal_i;
      exp_q.push_back(enq_addr_i);
      tick();
      enq_valid_i = 1'b0;
      $display("c5 iter %0d pushed %0h count=%0d", it, enq_addr_i, count_o);
    end
    while (exp_q.size() > 0) begin
      wait_en(exp_q.pop_front(), "c5 drain");
      tick();
    end
    tick(); tick(); tick();
    chk("c5 empty count", count_o, 3'd0);
    chk("c5 empty busy", busy_o, 1'b0);

    // ---- Case 6: flush_i during WAIT with simultaneous push; late flag ignored
    enq_valid_i = 1'b1; enq_addr_i = 32'h600; enq_inst_i = jal_i;
    tick();
    enq_addr_i = 32'h604;
    tick();
    enq_valid_i = 1'b0;
    wait_en(32'h600, "c6 first");
    tick();
    chk("c6 wait1 count", count_o, 3'd1);
    flush_i = 1'b1; enq_valid_i = 1'b1; enq_addr_i = 32'h608;
    tick();
    flush_i = 1'b0; enq_valid_i = 1'b0;
    chk("c6 flushed count", count_o, 3'd0);
    chk("c6 flushed busy", busy_o, 1'b0);
    chk("c6 flushed en", iq_jump_0_en_o, 1'b0);
    jump_flag_i = 1'b1;
    tick();
    jump_flag_i = 1'b0;
    chk("c6 late flag ready", enq_ready_o, 1'b1);
    chk("c6 late flag busy", busy_o, 1'b0);
    chk("c6 late flag en", iq_jump_0_en_o, 1'b0);
    enq_valid_i = 1'b1; enq_addr_i = 32'h60C;
    tick();
    enq_valid_i = 1'b0;
    tick();
    chk("c6 new issue en", iq_jump_0_en_o, 1'b1);
    chk("c6 new issue addr", iq_jump_0_addr_o, 32'h60C);
    tick(); tick(); tick();
    chk("c6 end count", count_o, 3'd0);
    $display("case6 external flush done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
